// File: rtl/mcht_rx.sv
// IEEE 802.3 Manchester receiver. Each bit is re-centred on its mid-bit edge,
// and the result is delivered as one registered word per frame.
module mcht_rx #(
  parameter int OSR    = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              rx_busy
);

  localparam int CW = ($clog2(OSR + 1) > 5) ? $clog2(OSR + 1) : 5;
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] C_ARM   = CW'(OSR);
  localparam logic [CW-1:0] C_GLCH  = CW'(OSR / 4 - 1);
  localparam logic [CW-1:0] C_FIRST = CW'(3 * OSR / 4 - 1);
  localparam logic [CW-1:0] C_WIN   = CW'(OSR / 2 - 1);
  localparam logic [BW-1:0] C_LAST  = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                win_q, win_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                sync1_q, sync2_q, prev_q;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                accept, timeout;

  logic edge_w, rise_w, armed_w;
  assign edge_w  = sync2_q ^ prev_q;
  assign rise_w  = sync2_q & ~prev_q;
  assign armed_w = (cnt_q == C_ARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      win_q   <= 1'b0;
      sh_q    <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      win_q   <= win_d;
      sh_q    <= sh_d;
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // In IDLE the cycle counter doubles as the low-time arming counter (saturates at OSR).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    win_d   = win_q;
    sh_d    = sh_q;
    accept  = 1'b0;
    timeout = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      win_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          win_d = 1'b0;
          bit_d = '0;
          if (rise_w && armed_w) begin
            state_d = START;
            cnt_d   = '0;
          end else if (sync2_q) begin
            cnt_d = '0;
          end else if (!armed_w) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_GLCH && !sync2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == C_FIRST) begin
            state_d = DATA;
            win_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        DATA: begin
          if (!win_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_FIRST) begin
              win_d = 1'b1;
              cnt_d = '0;
            end
          end else if (edge_w) begin
            sh_d  = {sh_q[DATA_W-2:0], sync2_q};
            bit_d = bit_q + 1'b1;
            cnt_d = '0;
            win_d = 1'b0;
            if (bit_q == C_LAST) begin
              accept  = 1'b1;
              state_d = IDLE;
              bit_d   = '0;
            end
          end else if (cnt_q == C_WIN) begin
            timeout = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            win_d   = 1'b0;
            bit_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          bit_d   = '0;
          win_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    valid_d = accept;
    err_d   = timeout;
    data_d  = accept ? {sh_q[DATA_W-2:0], sync2_q} : data_q;
    busy_d  = (state_d != IDLE);
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign rx_busy  = busy_q;

endmodule

// File: tb/tb_mcht_rx.sv
// Bench for mcht_rx: table of frames checked through a scoreboard queue, plus
// hand-written error, glitch, reset and enable-abort sequences.
module tb_mcht_rx;

  localparam int OSR = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst, en, rx_in;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_err, rx_busy;

  mcht_rx #(.OSR(OSR), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_errp   = 0;
  int n_busy   = 0;
  int last_mid = 0;
  logic [DW-1:0] sbq[$];
  logic [DW-1:0] exp_w;

  typedef struct {
    logic [DW-1:0] data;
    int            period;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rx_busy) n_busy++;
    if (rx_err) n_errp++;
    if (rx_valid) begin
      n_valid++;
      check("valid_err_exclusive", int'(rx_err), 0);
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_w = sbq.pop_front();
        check("rx_data", int'(rx_data), int'(exp_w));
        check("latency", cyc - last_mid, 3);
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    rx_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    hold(~b, p / 2);
    rx_in    = b;
    last_mid = cyc;
    repeat (p - p / 2) @(negedge clk);
  endtask

  // Sends start bit plus the first nbits data bits; bit index 'flat' keeps the line level.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input int nbits, input int flat);
    send_bit(1'b1, p);
    for (int i = 0; i < nbits; i++) begin
      if (i == flat) hold(rx_in, p);
      else send_bit(d[DW-1-i], p);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rx_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data",  int'(rx_data), 0);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_err",   int'(rx_err), 0);
    check("reset_busy",  int'(rx_busy), 0);
    rst = 1'b0; en = 1'b1;
    hold(1'b0, 32);

    vt[0] = '{8'hA5, 16, 8'hA5};
    vt[1] = '{8'h00, 16, 8'h00};
    vt[2] = '{8'hFF, 16, 8'hFF};
    vt[3] = '{8'h3C, 16, 8'h3C};
    vt[4] = '{8'h5A, 14, 8'h5A};
    vt[5] = '{8'h5A, 18, 8'h5A};
    n_valid = 0; n_errp = 0;
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(vt[i].exp);
      send_frame(vt[i].data, vt[i].period, DW, -1);
      hold(1'b0, 16);
    end
    hold(1'b0, 40);
    check("table_drained", sbq.size(), 0);
    check("table_valid_count", n_valid, 6);
    check("table_err_count", n_errp, 0);

    // Missing mid-bit edge.
    n_valid = 0; n_errp = 0;
    send_frame(8'hC3, 16, 5, 4);
    hold(1'b0, 40);
    check("viol_err_count", n_errp, 1);
    check("viol_valid_count", n_valid, 0);
    check("viol_data_kept", int'(rx_data), 8'h5A);
    sbq.push_back(8'h81);
    send_frame(8'h81, 16, DW, -1);
    hold(1'b0, 40);
    check("recover_valid_count", n_valid, 1);
    check("recover_data", int'(rx_data), 8'h81);
    check("recover_drained", sbq.size(), 0);

    // Short glitch on an idle, armed line.
    n_valid = 0; n_errp = 0; n_busy = 0;
    hold(1'b1, 2);
    hold(1'b0, 40);
    check("glitch_busy_seen", int'(n_busy > 0), 1);
    check("glitch_busy_short", int'(n_busy < 8), 1);
    check("glitch_valid", n_valid, 0);
    check("glitch_err", n_errp, 0);

    // Reset mid-frame, then enable drop mid-frame.
    n_valid = 0; n_errp = 0;
    send_frame(8'h96, 16, 4, -1);
    check("pre_rst_busy", int'(rx_busy), 1);
    rst = 1'b1;
    #1;
    check("rst_async_busy",  int'(rx_busy), 0);
    check("rst_async_data",  int'(rx_data), 0);
    check("rst_async_valid", int'(rx_valid), 0);
    check("rst_async_err",   int'(rx_err), 0);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 32);
    send_frame(8'h96, 16, 4, -1);
    en = 1'b0;
    @(negedge clk);
    check("en_abort_busy", int'(rx_busy), 0);
    hold(1'b0, 20);
    en = 1'b1;
    hold(1'b0, 32);
    check("abort_valid", n_valid, 0);
    check("abort_err", n_errp, 0);
    check("abort_data", int'(rx_data), 0);
    sbq.push_back(8'h96);
    send_frame(8'h96, 16, DW, -1);
    hold(1'b0, 40);
    check("final_valid_count", n_valid, 1);
    check("final_data", int'(rx_data), 8'h96);
    check("final_err", n_errp, 0);
    check("final_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mcht_rx.md
MCHT_RX -- requirements
Module: mcht_rx

Interface
REQ-001 Parameter OSR, default 16, clk cycles per nominal Manchester bit period; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter DATA_W, default 8, data bits per frame.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high; it SHALL force all state to reset values immediately, independent of clk.
REQ-005 en  input  1  receiver enable; low SHALL hold the FSM in IDLE with no outputs pulsed.
REQ-006 rx_in  input  1  asynchronous Manchester line; idle level is 0.
REQ-007 rx_data  output  DATA_W  last correctly received word, MSB first on the line.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-009 rx_err  output  1  one-cycle pulse on a Manchester violation inside a frame.
REQ-010 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Line coding SHALL be IEEE 802.3: a mid-bit rising transition is 1, a falling transition is 0; the bit value is the level after the mid-bit transition.
REQ-012 Frame SHALL consist of a start bit (1), then DATA_W data bits MSB first, then at least one bit period of idle-low line.
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; an edge SHALL be detected by comparing the synchronized sample with its one-cycle-delayed copy.
REQ-014 States: IDLE, START, DATA; a 5-bit+ cycle counter and a bit counter of ceil(log2(DATA_W+1)) bits.
REQ-015 IDLE: arm only after the synchronized line has been low for OSR consecutive cycles; while armed, a rising edge SHALL move to START and clear the cycle counter.
REQ-016 IDLE: falling edges, and rising edges while unarmed, SHALL be ignored.
REQ-017 START: at OSR/4 cycles after the edge the line SHALL be sampled; if low, return to IDLE silently (glitch reject, no rx_err); if high, continue.
REQ-018 START/DATA: the first-half sample of the next bit SHALL be taken 3*OSR/4 cycles after the last mid-bit edge; then enter the transition window.
REQ-019 Transition window: the first edge within OSR/2 cycles after the first-half sample is the mid-bit edge; the bit value is the new level, it SHALL be shifted into a shift register, and the cycle counter SHALL be cleared (re-centering on every bit).
REQ-020 No edge within the window SHALL pulse rx_err for one cycle, discard the partial word, leave rx_data unchanged, and return to IDLE unarmed.
REQ-021 After DATA_W bits are accepted, rx_data SHALL load the shift register and rx_valid SHALL pulse for one cycle in the same cycle; the FSM returns to IDLE unarmed.
REQ-022 Latency: rx_valid SHALL rise on the 3rd rising clk edge after the final mid-bit transition on rx_in (the edge first sampling it counts as 1).
REQ-023 rx_valid and rx_err SHALL never assert in the same cycle.
REQ-024 Bit-period tolerance: frames with constant bit period in OSR-OSR/8 .. OSR+OSR/8 cycles SHALL decode correctly.
REQ-025 en deasserted mid-frame SHALL abort to IDLE unarmed within one cycle, with no rx_valid and no rx_err.
REQ-026 rx_busy SHALL be registered and equal (state != IDLE).

Reset
REQ-027 On rst: state IDLE unarmed, synchronizer flops 0, counters 0, rx_data 0, rx_valid 0, rx_err 0, rx_busy 0.
REQ-028 rst asserted mid-frame SHALL discard the frame; after release, a new frame SHALL decode only after the REQ-015 low-time arming.

Verification
REQ-029 OSR=16, en=1, idle 32 cycles, send 0xA5 at 16 cycles/bit -> exactly one rx_valid pulse with rx_data=0xA5, rx_err never high, and rx_valid on the 3rd edge after the last mid-bit transition.
REQ-030 Back-to-back 0x00, 0xFF, 0x3C separated by 16 idle-low cycles -> three rx_valid pulses in order, data 0x00, 0xFF, 0x3C.
REQ-031 Send 0x5A at 14 cycles/bit, then at 18 cycles/bit -> rx_data=0x5A both times, no rx_err.
REQ-032 Send 0xC3 with bit 4 held flat for a full bit period -> one rx_err pulse, no rx_valid, rx_data keeps its previous value; the next valid frame 0x81 -> rx_data=0x81.
REQ-033 A 2-cycle high glitch on idle rx_in -> rx_busy pulses briefly, no rx_valid, no rx_err.
REQ-034 Assert rst for 1 cycle mid-way through 0x96, then en=0 mid-way through a second frame -> all outputs 0 immediately, no pulses; the following 0x96 frame with en=1 decodes correctly.
